// File: rtl/sdram_test_sequencer.sv
// sdram_test_sequencer: writes a deterministic pattern over 0..LAST_ADDR, reads it back and checks it
//   sys_clk, sys_reset_n         clock, asynchronous active-low reset
//   start, mode                  run request pulse and pattern select (0 = address, 1 = LFSR)
//   busy, done, pass             run status; pass is valid while done=1
//   err_count, first_err_*       saturating mismatch count, address and read data of the first mismatch
//   ctl_cmd/addr/wdata/ready     command port to the controller (held until accepted)
//   ctl_rdata, ctl_rvalid        read return from the controller
module sdram_test_sequencer #(
    parameter int                ADDR_W    = 23,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
    parameter logic [15:0]       SEED      = 16'hACE1
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [1:0]        ctl_cmd,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_ready,
    input  logic [DATA_W-1:0] ctl_rdata,
    input  logic              ctl_rvalid
);
    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, FIN} state_t;
    localparam logic [1:0] NOP = 2'b00, WRITE = 2'b01, READ = 2'b10;
    // an all-zero seed would lock the LFSR at zero
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction
    function automatic logic [DATA_W-1:0] pattern(input logic m, input logic [ADDR_W-1:0] a,
                                                  input logic [15:0] s);
        logic [22:0] a23;
        a23 = 23'(a);
        return DATA_W'(m ? s : a23[15:0] ^ {a23[22:16], 9'b0});
    endfunction
    state_t            state_q;
    logic              mode_q, busy_q, done_q, pass_q;
    logic [ADDR_W-1:0] addr_q, addr_d, ctl_addr_q, first_err_addr_q;
    logic [15:0]       lfsr_q, lfsr_d, err_q, err_d;
    logic [DATA_W-1:0] ctl_wdata_q, first_err_data_q;
    logic [1:0]        ctl_cmd_q;
    logic              at_last, mismatch;
    always_comb begin
        addr_d   = addr_q + ADDR_W'(1);
        lfsr_d   = lfsr_step(lfsr_q);
        at_last  = addr_q == LAST_ADDR;
        mismatch = ctl_rdata != pattern(mode_q, addr_q, lfsr_q);
        err_d    = (mismatch && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q          <= IDLE;
            mode_q           <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            addr_q           <= '0;
            lfsr_q           <= '0;
            err_q            <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            ctl_cmd_q        <= NOP;
            ctl_addr_q       <= '0;
            ctl_wdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    mode_q           <= mode;
                    err_q            <= '0;
                    first_err_addr_q <= '0;
                    first_err_data_q <= '0;
                    done_q           <= 1'b0;
                    pass_q           <= 1'b0;
                    busy_q           <= 1'b1;
                    addr_q           <= '0;
                    lfsr_q           <= SEED_EFF;
                    ctl_cmd_q        <= WRITE;
                    ctl_addr_q       <= '0;
                    ctl_wdata_q      <= pattern(mode, '0, SEED_EFF);
                    state_q          <= WR;
                end
                WR: if (ctl_ready) begin
                    if (at_last) begin
                        addr_q     <= '0;
                        lfsr_q     <= SEED_EFF;
                        ctl_cmd_q  <= READ;
                        ctl_addr_q <= '0;
                        state_q    <= RD_ISSUE;
                    end else begin
                        addr_q      <= addr_d;
                        lfsr_q      <= lfsr_d;
                        ctl_addr_q  <= addr_d;
                        ctl_wdata_q <= pattern(mode_q, addr_d, lfsr_d);
                    end
                end
                RD_ISSUE: if (ctl_ready) begin
                    ctl_cmd_q <= NOP;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: if (ctl_rvalid) begin
                    err_q <= err_d;
                    // a saturated count is never zero again, so capture happens once per run
                    if (mismatch && err_q == 16'd0) begin
                        first_err_addr_q <= addr_q;
                        first_err_data_q <= ctl_rdata;
                    end
                    if (at_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_d == 16'd0;
                        state_q <= FIN;
                    end else begin
                        addr_q     <= addr_d;
                        lfsr_q     <= lfsr_d;
                        ctl_cmd_q  <= READ;
                        ctl_addr_q <= addr_d;
                        state_q    <= RD_ISSUE;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
    assign ctl_cmd        = ctl_cmd_q;
    assign ctl_addr       = ctl_addr_q;
    assign ctl_wdata      = ctl_wdata_q;
endmodule

// File: tb/tb_sdram_test_sequencer.sv
// tb_sdram_test_sequencer: directed bench for sdram_test_sequencer over an 8-word range with a latency-3 memory model
module tb_sdram_test_sequencer;
    localparam int AW = 23, DW = 16;
    typedef struct {
        logic        m;
        logic        cor;
        logic        p;
        logic [15:0] ec;
        logic [22:0] fa;
        logic [15:0] fd;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;
    logic sys_clk = 1'b0, sys_reset_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic busy, done, pass;
    logic [15:0] err_count;
    logic [AW-1:0] first_err_addr, ctl_addr;
    logic [DW-1:0] first_err_data, ctl_wdata, ctl_rdata;
    logic [1:0] ctl_cmd;
    logic ctl_ready, ctl_rvalid;
    logic hold_a3 = 1'b0, corrupt = 1'b0, spur = 1'b0, clr_log = 1'b0;
    logic [15:0] mem [8];
    logic [15:0] wr_log [8];
    int wr_cnt [8];
    int rd_cnt, bad_cmd;
    logic [2:0] pv = 3'b000;
    logic [2:0] pa0, pa1, pa2;
    int checks = 0, errors = 0;
    vec_t vecs [4];
    sdram_test_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(23'd7), .SEED(16'hACE1)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_ready(ctl_ready), .ctl_rdata(ctl_rdata), .ctl_rvalid(ctl_rvalid)
    );
    always #5 sys_clk = ~sys_clk;
    assign ctl_ready  = !(hold_a3 && ctl_cmd == 2'b01 && ctl_addr == 23'd3);
    assign ctl_rvalid = pv[2] | spur;
    assign ctl_rdata  = spur ? 16'h5555 : (corrupt && pa2 == 3'd5) ? 16'hDEAD :
                        (corrupt && pa2 == 3'd6) ? mem[pa2] ^ 16'h0001 : mem[pa2];
    always @(posedge sys_clk) begin
        pv  <= {pv[1:0], ctl_cmd == 2'b10 && ctl_ready};
        pa0 <= ctl_addr[2:0];
        pa1 <= pa0;
        pa2 <= pa1;
        if (clr_log) begin
            for (int i = 0; i < 8; i++) wr_cnt[i] <= 0;
            rd_cnt  <= 0;
            bad_cmd <= 0;
        end else begin
            if (ctl_cmd == 2'b11 || (ctl_cmd != 2'b00 && ctl_addr > 23'd7)) bad_cmd <= bad_cmd + 1;
            if (ctl_cmd == 2'b01 && ctl_ready) begin
                mem[ctl_addr[2:0]]    <= ctl_wdata;
                wr_log[ctl_addr[2:0]] <= ctl_wdata;
                wr_cnt[ctl_addr[2:0]] <= wr_cnt[ctl_addr[2:0]] + 1;
            end
            if (ctl_cmd == 2'b10 && ctl_ready) rd_cnt <= rd_cnt + 1;
        end
    end
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic clear_log();
        @(negedge sys_clk);
        clr_log = 1'b1;
        @(negedge sys_clk);
        clr_log = 1'b0;
    endtask
    task automatic run_start(input logic m);
        @(negedge sys_clk);
        mode  = m;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
    endtask
    task automatic check_run(input string tag, input vec_t v);
        bit ok;
        int bad;
        logic [15:0] s;
        wait_done(ok);
        chk({tag, "_done"}, ok, 1);
        chk({tag, "_busy_at_fin"}, busy, 0);
        chk({tag, "_pass"}, pass, v.p);
        chk({tag, "_err_count"}, err_count, v.ec);
        chk({tag, "_first_addr"}, first_err_addr, v.fa);
        chk({tag, "_first_data"}, first_err_data, v.fd);
        chk({tag, "_wdata0"}, wr_log[0], v.w0);
        chk({tag, "_wdata1"}, wr_log[1], v.w1);
        bad = 0;
        s = 16'hACE1;
        for (int i = 0; i < 8; i++) begin
            if (wr_cnt[i] != 1 || wr_log[i] != (v.m ? s : 16'(i))) bad++;
            s = lfsr_step(s);
        end
        chk({tag, "_write_seq_bad"}, bad, 0);
        chk({tag, "_reads"}, rd_cnt, 8);
        chk({tag, "_bad_cmd"}, bad_cmd, 0);
        @(negedge sys_clk);
        chk({tag, "_idle_hold"}, {done, busy, pass}, {1'b1, 1'b0, v.p});
    endtask
    initial begin
        bit ok;
        int unstable;
        vecs[0] = '{m: 1'b0, cor: 1'b0, p: 1'b1, ec: 16'd0, fa: 23'd0, fd: 16'h0000, w0: 16'h0000, w1: 16'h0001};
        vecs[1] = '{m: 1'b1, cor: 1'b0, p: 1'b1, ec: 16'd0, fa: 23'd0, fd: 16'h0000, w0: 16'hACE1, w1: 16'hE270};
        vecs[2] = '{m: 1'b0, cor: 1'b1, p: 1'b0, ec: 16'd2, fa: 23'd5, fd: 16'hDEAD, w0: 16'h0000, w1: 16'h0001};
        vecs[3] = '{m: 1'b1, cor: 1'b1, p: 1'b0, ec: 16'd2, fa: 23'd5, fd: 16'hDEAD, w0: 16'hACE1, w1: 16'hE270};
        repeat (3) @(negedge sys_clk);
        chk("rst_flags", {busy, done, pass, ctl_cmd}, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", {first_err_addr, first_err_data}, 0);
        chk("rst_ctl", {ctl_addr, ctl_wdata}, 0);
        sys_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            corrupt = vecs[i].cor;
            clear_log();
            run_start(vecs[i].m);
            check_run($sformatf("vec%0d", i), vecs[i]);
        end
        corrupt = 1'b0;
        clear_log();
        hold_a3 = 1'b1;
        run_start(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ctl_cmd == 2'b01 && ctl_addr == 23'd3) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        chk("stall_reached", ok, 1);
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            if (!(ctl_cmd == 2'b01 && ctl_addr == 23'd3 && ctl_wdata == 16'd3)) unstable++;
        end
        chk("stall_stable", unstable, 0);
        hold_a3 = 1'b0;
        check_run("stall", vecs[0]);
        chk("stall_addr3_once", wr_cnt[3], 1);
        clear_log();
        run_start(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rd_cnt == 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        chk("midrst_reached", ok, 1);
        chk("midrst_in_wait", {ctl_cmd, busy}, {2'b00, 1'b1});
        #2 sys_reset_n = 1'b0;
        #1;
        chk("midrst_flags", {busy, done, pass, ctl_cmd}, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_ctl", {ctl_addr, ctl_wdata}, 0);
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        clear_log();
        run_start(1'b0);
        check_run("after_rst", vecs[0]);
        clear_log();
        run_start(1'b0);
        @(negedge sys_clk);
        spur  = 1'b1;
        mode  = 1'b1;
        start = 1'b1;
        @(negedge sys_clk);
        spur  = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        spur = 1'b1;
        @(negedge sys_clk);
        spur = 1'b0;
        check_run("busy_start", vecs[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_test_sequencer.md
Name: sdram_test_sequencer

Overview:
Pattern generator and checker that sits directly upstream of the SDRAM controller's host port. On a start pulse it writes a deterministic pattern to every word in an address range, then reads each word back and compares it against the regenerated pattern. It reports pass/fail, a saturating error count and the first failing address and data, which feed the board-level status LEDs/UART.

Parameters:
ADDR_W, 23, host word-address width (matches controller sys_addr)
DATA_W, 16, data word width (matches controller data bus)
LAST_ADDR, 23'h7FFFFF, final address tested; range is 0..LAST_ADDR inclusive
SEED, 16'hACE1, LFSR seed for mode 1; a value of 0 is replaced by 16'h0001

Ports:
sys_clk  in  1  system clock, same clock as the controller host side
sys_reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
mode  in  1  pattern select, sampled at start: 0 = address-derived, 1 = LFSR
busy  out  1  high from the cycle after start until done rises
done  out  1  high from run completion until the next accepted start
pass  out  1  valid while done=1; 1 when err_count==0
err_count  out  16  number of mismatching words, saturates at 16'hFFFF
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_data  out  DATA_W  read data of the first mismatch
ctl_cmd  out  2  00 = NOP, 01 = WRITE, 10 = READ, 11 = reserved (never driven)
ctl_addr  out  ADDR_W  command address
ctl_wdata  out  DATA_W  write data
ctl_ready  in  1  controller can accept a command this cycle
ctl_rdata  in  DATA_W  read data
ctl_rvalid  in  1  one-cycle strobe, ctl_rdata valid

Behaviour:
- Reset (async, sys_reset_n=0): state IDLE; all outputs 0 (busy, done, pass, err_count, first_err_*, ctl_cmd=NOP, ctl_addr, ctl_wdata). Reset mid-run aborts immediately; no command is left asserted.
- Command handshake: a command is accepted on a rising edge where ctl_cmd!=NOP and ctl_ready=1. ctl_cmd, ctl_addr and ctl_wdata stay stable until acceptance. ctl_cmd returns to NOP on the cycle after acceptance unless the next command is already permitted. At most one READ is outstanding.
- Pattern mode 0: data = addr[15:0] ^ {addr[22:16], 9'b0}.
- Pattern mode 1: 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1, loaded with SEED at the start of each phase. It advances once per accepted WRITE in the write phase and once per compare in the read phase, so both phases produce the same sequence.
- States:
  - IDLE: start=1 latches mode, clears err_count, first_err_*, done and pass, sets addr=0, loads the LFSR, sets busy, and goes to WR. start while busy is ignored.
  - WR: drives WRITE with addr and pattern. On acceptance: if addr==LAST_ADDR, reset addr to 0, reload the LFSR and go to RD_ISSUE; otherwise increment addr.
  - RD_ISSUE: drives READ with addr. On acceptance, go to RD_WAIT.
  - RD_WAIT: ctl_cmd=NOP. On ctl_rvalid, compare ctl_rdata against the expected pattern.
    - On mismatch: err_count += 1 (saturating). If this is the first error, capture addr and ctl_rdata.
    - Then: if addr==LAST_ADDR, go to FIN; otherwise increment addr, advance the pattern and return to RD_ISSUE.
  - A ctl_rvalid received outside RD_WAIT is ignored.
  - FIN (one cycle): busy=0; done=1; pass=(err_count==0). Go to IDLE.
- done and pass hold in IDLE until the next accepted start.
- Counter widths: addr is ADDR_W bits. LAST_ADDR=2^ADDR_W-1 must terminate by the equality check, with no wrap-around.
- A start arriving in the same cycle as FIN is ignored.
- Minimum run latency with ctl_ready held at 1 and read latency L: about 2*(LAST_ADDR+1) + (LAST_ADDR+1)*L + 2 cycles.

Test Plan:
- LAST_ADDR=7, mode 0, ideal memory model (ready=1, read latency 3) -> 8 WRITEs to addresses 0..7 with data 0..7 then 8 READs; done=1, pass=1, err_count=0, busy low after FIN.
- Same setup, mode 1, SEED=16'hACE1 -> first write data 16'hACE1, and the read-phase expected sequence equals the write sequence; pass=1.
- Model corrupts the read of addr 5 (returns 16'hDEAD) and addr 6 -> err_count=2, first_err_addr=5, first_err_data=16'hDEAD, pass=0.
- ctl_ready held low for 10 cycles during WR at addr 3 -> ctl_cmd, ctl_addr and ctl_wdata stay stable the whole time; exactly one WRITE is accepted for addr 3.
- sys_reset_n pulsed low during RD_WAIT -> all outputs 0 asynchronously; a subsequent start runs a full, correct pass.
- start pulsed while busy, plus spurious ctl_rvalid during WR -> neither affects the run; final err_count=0.
